// File: rtl/pipelined_segmented_adder.sv
// pipelined_segmented_adder
//   Adds or subtracts a narrower unsigned operand B from A. B is zero-extended
//   to WIDTH_A. The carry chain is cut into SEG_W-bit segments, and each
//   segment gets its own pipeline stage. Every stage has its own valid bit, so
//   a stall only blocks a stage when every stage downstream of it is full.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   A, B and op_sub are valid
//   in_ready   stage 0 can accept this cycle
//   A          operand A, unsigned, WIDTH_A bits
//   B          operand B, unsigned, WIDTH_B bits, zero-extended
//   op_sub     0: Sum = A + B   1: Sum = A + ~Bext + 1
//   out_valid  Sum is valid
//   out_ready  downstream accepts Sum
//   Sum        {carry_out, result}, WIDTH_A+1 bits
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds its payload stable while valid is 1 and ready is 0.
// Ready never depends combinationally on valid from the same side. in_ready
// is built combinationally from out_ready back through the stage valid bits.
module pipelined_segmented_adder #(
  parameter int WIDTH_A = 44,
  parameter int WIDTH_B = 43,
  parameter int SEG_W   = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  input  logic               op_sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A:0]   Sum
);

  localparam int NSEG = (WIDTH_A + SEG_W - 1) / SEG_W;
  // Operand de-skew registers exist only between stages. Keep at least one
  // entry so that the array stays legal when NSEG is 1.
  localparam int NOP = (NSEG > 1) ? NSEG - 1 : 1;
  localparam logic [WIDTH_A-1:0] ONES = '1;

  if (WIDTH_B > WIDTH_A || WIDTH_B < 1) begin : g_bad_width_b
    $error("pipelined_segmented_adder: WIDTH_B must be in 1..WIDTH_A");
  end
  if (SEG_W < 1 || SEG_W > WIDTH_A) begin : g_bad_seg_w
    $error("pipelined_segmented_adder: SEG_W must be in 1..WIDTH_A");
  end

  // Per-stage state: valid, carry out of the segment, and the result so far.
  logic [NSEG-1:0]    r_v;
  logic [NSEG-1:0]    r_c;
  logic [WIDTH_A-1:0] r_res [NSEG];
  // Operands still waiting for later stages (de-skew).
  logic [WIDTH_A-1:0] r_a   [NOP];
  logic [WIDTH_A-1:0] r_y   [NOP];

  // Inputs that each stage sees: the ports for stage 0, else the previous stage.
  logic [NSEG-1:0]    w_vsrc;
  logic [NSEG-1:0]    w_csrc;
  logic [WIDTH_A-1:0] w_asrc [NSEG];
  logic [WIDTH_A-1:0] w_ysrc [NSEG];
  logic [WIDTH_A-1:0] w_rsrc [NSEG];
  logic [WIDTH_A-1:0] w_rnext [NSEG];
  logic [NSEG-1:0]    w_cnext;
  logic [NSEG-1:0]    w_load;
  logic [WIDTH_A-1:0] w_bext;

  assign w_bext = WIDTH_A'(B);

  always_comb begin : p_src
    w_vsrc = '0;
    w_csrc = '0;
    for (int k = 0; k < NSEG; k++) begin
      w_asrc[k] = '0;
      w_ysrc[k] = '0;
      w_rsrc[k] = '0;
    end
    // Subtraction is A + ~Bext with a carry-in of 1 at segment 0.
    w_vsrc[0] = in_valid;
    w_csrc[0] = op_sub;
    w_asrc[0] = A;
    w_ysrc[0] = op_sub ? ~w_bext : w_bext;
    for (int k = 1; k < NSEG; k++) begin
      w_vsrc[k] = r_v[k-1];
      w_csrc[k] = r_c[k-1];
      w_asrc[k] = r_a[k-1];
      w_ysrc[k] = r_y[k-1];
      w_rsrc[k] = r_res[k-1];
    end
  end

  // One segment adder per stage. The top segment is narrower when WIDTH_A
  // is not a multiple of SEG_W.
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO = k * SEG_W;
    localparam int SW = (k == NSEG - 1) ? WIDTH_A - LO : SEG_W;
    // Result bits below this segment come from earlier stages (skew path).
    localparam logic [WIDTH_A-1:0] LMASK = ONES >> (WIDTH_A - LO);

    logic [SW-1:0] w_as;
    logic [SW-1:0] w_ys;
    logic [SW:0]   w_s;

    assign w_as       = SW'(w_asrc[k] >> LO);
    assign w_ys       = SW'(w_ysrc[k] >> LO);
    assign w_s        = {1'b0, w_as} + {1'b0, w_ys} + {{SW{1'b0}}, w_csrc[k]};
    assign w_rnext[k] = (w_rsrc[k] & LMASK) | (WIDTH_A'(w_s[SW-1:0]) << LO);
    assign w_cnext[k] = w_s[SW];
  end

  // A stage may load when it is empty or its contents move on this edge.
  // Walk from the output back toward the input.
  always_comb begin : p_load
    logic ld;
    w_load = '0;
    ld     = out_ready;
    for (int k = NSEG - 1; k >= 0; k--) begin
      ld        = !r_v[k] | ld;
      w_load[k] = ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_c <= '0;
      for (int k = 0; k < NSEG; k++) r_res[k] <= '0;
      for (int k = 0; k < NOP; k++) begin
        r_a[k] <= '0;
        r_y[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (w_load[k]) begin
          r_v[k] <= w_vsrc[k];
          // Data moves only with a valid token. A bubble keeps the old
          // payload, so Sum stays put after an output drains.
          if (w_vsrc[k]) begin
            r_res[k] <= w_rnext[k];
            r_c[k]   <= w_cnext[k];
          end
        end
      end
      for (int k = 0; k < NSEG - 1; k++) begin
        if (w_load[k] && w_vsrc[k]) begin
          r_a[k] <= w_asrc[k];
          r_y[k] <= w_ysrc[k];
        end
      end
    end
  end

  assign in_ready  = w_load[0];
  assign out_valid = r_v[NSEG-1];
  assign Sum       = {r_c[NSEG-1], r_res[NSEG-1]};

endmodule
